// File: rtl/mmc1_pkg.sv
// rtl/mmc1_pkg.sv - shared encodings and bus record for the MMC1 serial loader
//
// Purpose: register-select encodings, shift-register marker value, the
// Control OR mask applied downstream on a serial reset, and the record of
// one CPU bus cycle as seen by the loader.
package mmc1_pkg;

    localparam logic [1:0] MMC1_SEL_CONTROL = 2'b00;
    localparam logic [1:0] MMC1_SEL_CHR0    = 2'b01;
    localparam logic [1:0] MMC1_SEL_CHR1    = 2'b10;
    localparam logic [1:0] MMC1_SEL_PRG     = 2'b11;

    // Marker bit in SR[4]: it reaches SR[0] after four shifts, so a set
    // SR[0] means the current write is the fifth one.
    localparam logic [4:0] MMC1_SR_INIT       = 5'b10000;
    localparam logic [4:0] MMC1_CTRL_RESET_OR = 5'b01100;

    typedef struct packed {
        logic romsel_n;
        logic rw_n;
        logic a14;
        logic a13;
        logic d7;
        logic d0;
    } mmc1_bus_t;

    function automatic logic mmc1_is_rom_write(input mmc1_bus_t b);
        return !b.romsel_n && !b.rw_n;
    endfunction

endpackage

// File: rtl/mmc1_bus_sync.sv
// rtl/mmc1_bus_sync.sv - CPU bus synchronizer, cycle capture and M2 fall detector
//
// Purpose: brings the asynchronous cartridge bus into the SYS_CLK domain,
// latches the bus fields while M2 is high and commits one CPU cycle on
// each synchronized M2 falling edge.
// Ports:
//   clk, rst  - fast clock, asynchronous active-high reset
//   m2        - raw CPU phi2
//   bus       - raw {nROMSEL, nRW, A14, A13, D7, D0}
//   cycle     - bus fields of the most recent M2-high phase
//   commit    - one-clock pulse: cycle holds a completed CPU cycle
module mmc1_bus_sync
    import mmc1_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      m2,
    input  mmc1_bus_t bus,
    output mmc1_bus_t cycle,
    output logic      commit
);

    logic [1:0] m2_sync;
    logic       m2_prev;
    mmc1_bus_t  bus_meta;
    mmc1_bus_t  bus_sync;
    mmc1_bus_t  capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_sync  <= 2'b00;
            m2_prev  <= 1'b0;
            bus_meta <= '0;
            bus_sync <= '0;
            capture  <= '0;
        end else begin
            m2_sync  <= {m2_sync[0], m2};
            m2_prev  <= m2_sync[1];
            bus_meta <= bus;
            bus_sync <= bus_meta;
            // Data and M2 share the same synchronizer depth, so the last
            // load before M2 drops holds the settled end-of-cycle bus.
            if (m2_sync[1]) begin
                capture <= bus_sync;
            end
        end
    end

    assign commit = m2_prev && !m2_sync[1];
    assign cycle  = capture;

endmodule

// File: rtl/mmc1_serial_loader.sv
// rtl/mmc1_serial_loader.sv - MMC1 serial write assembler and M2 watchdog
//
// Purpose: turns committed CPU ROM writes into MMC1 register-write and
// serial-reset strobes, and watches M2 for loss of the CPU clock.
// Optional feature: MMC1_CONSEC_WRITE_FILTER_EN ignores a ROM write whose
// previous committed CPU cycle was also a ROM write.
// Ports:
//   SYS_CLK, SYS_RST           - fast clock, asynchronous active-high reset
//   CPU_M2, nCPU_ROMSEL,
//   nCPU_RW, CPU_A14, CPU_A13,
//   CPU_D7, CPU_D0             - raw cartridge bus
//   REG_WE                     - one-clock pulse, register write complete
//   REG_SEL, REG_DATA          - target and value of the last register write
//   RESET_STB                  - one-clock pulse, serial reset (D7=1 write)
//   M2_ALIVE                   - M2 falling edges are arriving
module mmc1_serial_loader
    import mmc1_pkg::*;
#(
    parameter int M2_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST,
    input  logic       CPU_M2,
    input  logic       nCPU_ROMSEL,
    input  logic       nCPU_RW,
    input  logic       CPU_A14,
    input  logic       CPU_A13,
    input  logic       CPU_D7,
    input  logic       CPU_D0,
    output logic       REG_WE,
    output logic [1:0] REG_SEL,
    output logic [4:0] REG_DATA,
    output logic       RESET_STB,
    output logic       M2_ALIVE
);

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(M2_TIMEOUT);

    mmc1_bus_t        bus_pins;
    mmc1_bus_t        cycle;
    logic             commit;
    logic             rom_write;
    logic             accept;
    logic [4:0]       sr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign bus_pins = '{romsel_n: nCPU_ROMSEL, rw_n: nCPU_RW, a14: CPU_A14,
                        a13: CPU_A13, d7: CPU_D7, d0: CPU_D0};

    mmc1_bus_sync u_bus_sync (
        .clk    (SYS_CLK),
        .rst    (SYS_RST),
        .m2     (CPU_M2),
        .bus    (bus_pins),
        .cycle  (cycle),
        .commit (commit)
    );

    assign rom_write = commit && mmc1_is_rom_write(cycle);

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    // Read-modify-write instructions write twice in consecutive cycles;
    // only the first of such a pair reaches the shift register.
    logic prev_write;

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            prev_write <= 1'b0;
        end else if (commit) begin
            prev_write <= mmc1_is_rom_write(cycle);
        end
    end

    assign accept = rom_write && !prev_write;
`else
    assign accept = rom_write;
`endif

    always_comb begin
        cnt_next = cnt;
        if (cnt != TIMEOUT) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            sr        <= MMC1_SR_INIT;
            cnt       <= '0;
            REG_WE    <= 1'b0;
            RESET_STB <= 1'b0;
            REG_SEL   <= 2'b00;
            REG_DATA  <= 5'b00000;
            M2_ALIVE  <= 1'b0;
        end else begin
            REG_WE    <= 1'b0;
            RESET_STB <= 1'b0;
            if (commit) begin
                // A falling edge always beats a simultaneous timeout.
                cnt      <= '0;
                M2_ALIVE <= 1'b1;
                if (accept) begin
                    if (cycle.d7) begin
                        sr        <= MMC1_SR_INIT;
                        RESET_STB <= 1'b1;
                    end else if (sr[0]) begin
                        REG_WE   <= 1'b1;
                        REG_SEL  <= {cycle.a14, cycle.a13};
                        REG_DATA <= {cycle.d0, sr[4:1]};
                        sr       <= MMC1_SR_INIT;
                    end else begin
                        sr <= {cycle.d0, sr[4:1]};
                    end
                end
            end else begin
                cnt <= cnt_next;
                // Lost M2: drop any partial serial value so a stale
                // prefix cannot combine with writes after recovery.
                if (cnt_next == TIMEOUT) begin
                    M2_ALIVE <= 1'b0;
                    sr       <= MMC1_SR_INIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// tb/tb_mmc1_serial_loader.sv - self-checking bench for mmc1_serial_loader
module tb_mmc1_serial_loader;

    localparam int T = 64;

    logic       SYS_CLK = 1'b0;
    logic       SYS_RST = 1'b1;
    logic       CPU_M2 = 1'b0;
    logic       nCPU_ROMSEL = 1'b1;
    logic       nCPU_RW = 1'b1;
    logic       CPU_A14 = 1'b0;
    logic       CPU_A13 = 1'b0;
    logic       CPU_D7 = 1'b0;
    logic       CPU_D0 = 1'b0;
    logic       REG_WE;
    logic [1:0] REG_SEL;
    logic [4:0] REG_DATA;
    logic       RESET_STB;
    logic       M2_ALIVE;

    mmc1_serial_loader #(.M2_TIMEOUT(T), .CNT_W(7)) dut (
        .SYS_CLK     (SYS_CLK),
        .SYS_RST     (SYS_RST),
        .CPU_M2      (CPU_M2),
        .nCPU_ROMSEL (nCPU_ROMSEL),
        .nCPU_RW     (nCPU_RW),
        .CPU_A14     (CPU_A14),
        .CPU_A13     (CPU_A13),
        .CPU_D7      (CPU_D7),
        .CPU_D0      (CPU_D0),
        .REG_WE      (REG_WE),
        .REG_SEL     (REG_SEL),
        .REG_DATA    (REG_DATA),
        .RESET_STB   (RESET_STB),
        .M2_ALIVE    (M2_ALIVE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n = 0;
    int tests = 0;
    int fails = 0;

    initial forever begin
        @(posedge SYS_CLK);
        n++;
    end

    // Expected strobe event at a given clock edge, one per committed cycle.
    typedef struct {
        int         at;
        bit         we;
        bit         rst;
        logic [1:0] sel;
        logic [4:0] data;
    } evt_t;

    evt_t       evq[$];
    bit         bits_q[$];
    bit         prev_wr = 1'b0;
    bit         m_have = 1'b0;
    int         m_last = 0;
    logic [4:0] m_last_data = 5'd0;

    bit         c_have = 1'b0;
    int         c_last = 0;
    logic [1:0] h_sel = 2'd0;
    logic [4:0] h_data = 5'd0;

    int         n_we = 0;
    int         n_rst = 0;
    logic [1:0] obs_sel = 2'd0;
    logic [4:0] obs_data = 5'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, n);
        end
    endtask

    // Reference: serial bits collected in a queue; fifth bit completes a write.
    task automatic model_commit(input bit rs, input bit rw, input bit a14, input bit a13,
                                input bit d7, input bit d0, input int at);
        evt_t e;
        bit   wr;
        bit   acc;
        e.at = at; e.we = 1'b0; e.rst = 1'b0; e.sel = 2'd0; e.data = 5'd0;
        if (m_have && (at - m_last > T)) bits_q.delete();
        m_have = 1'b1;
        m_last = at;
        wr  = !rs && !rw;
        acc = wr;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        acc = wr && !prev_wr;
        prev_wr = wr;
`endif
        if (acc) begin
            if (d7) begin
                bits_q.delete();
                e.rst = 1'b1;
            end else if (bits_q.size() == 4) begin
                e.we = 1'b1;
                e.sel = {a14, a13};
                e.data[4] = d0;
                for (int i = 0; i < 4; i++) e.data[i] = bits_q[i];
                m_last_data = e.data;
                bits_q.delete();
            end else begin
                bits_q.push_back(d0);
            end
        end
        evq.push_back(e);
    endtask

    task automatic cpu_cycle(input bit rs, input bit rw, input bit a14, input bit a13,
                             input bit d7, input bit d0, input int hi, input int lo);
        @(posedge SYS_CLK); #1;
        CPU_M2 = 1'b1; nCPU_ROMSEL = rs; nCPU_RW = rw;
        CPU_A14 = a14; CPU_A13 = a13; CPU_D7 = d7; CPU_D0 = d0;
        repeat (hi) @(posedge SYS_CLK);
        #1;
        CPU_M2 = 1'b0;
        // M2 falls before edge n+1, so the strobe is registered at edge n+3.
        model_commit(rs, rw, a14, a13, d7, d0, n + 3);
        repeat (lo - 1) @(posedge SYS_CLK);
    endtask

    // One serial write followed by a ROM read, so the filter never applies.
    task automatic sw(input bit a14, input bit a13, input bit d7, input bit d0);
        cpu_cycle(1'b0, 1'b0, a14, a13, d7, d0, 4, 4);
        cpu_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3);
    endtask

    task automatic do_reset();
        repeat (4) @(posedge SYS_CLK);
        #1;
        SYS_RST = 1'b1;
        bits_q.delete(); evq.delete();
        prev_wr = 1'b0; m_have = 1'b0;
        c_have = 1'b0; h_sel = 2'd0; h_data = 5'd0;
        repeat (3) @(posedge SYS_CLK);
        #1;
        SYS_RST = 1'b0;
    endtask

    task automatic clear_obs();
        n_we = 0; n_rst = 0;
    endtask

    // Cycle-by-cycle comparison against the reference model.
    initial forever begin
        bit   ew;
        bit   er;
        bit   ea;
        evt_t e;
        @(negedge SYS_CLK);
        ew = 1'b0; er = 1'b0;
        if (SYS_RST) begin
            check("rst_reg_we", REG_WE, 0);
            check("rst_reset_stb", RESET_STB, 0);
            check("rst_reg_sel", REG_SEL, 0);
            check("rst_reg_data", REG_DATA, 0);
            check("rst_m2_alive", M2_ALIVE, 0);
        end else begin
            if (evq.size() > 0 && evq[0].at == n) begin
                e = evq.pop_front();
                ew = e.we; er = e.rst;
                if (e.we) begin h_sel = e.sel; h_data = e.data; end
                c_have = 1'b1; c_last = n;
            end
            ea = c_have && (n - c_last < T);
            check("reg_we", REG_WE, ew);
            check("reset_stb", RESET_STB, er);
            check("reg_sel", REG_SEL, h_sel);
            check("reg_data", REG_DATA, h_data);
            check("m2_alive", M2_ALIVE, ea);
        end
        if (REG_WE === 1'b1) begin n_we++; obs_sel = REG_SEL; obs_data = REG_DATA; end
        if (RESET_STB === 1'b1) n_rst++;
    end

    initial begin
        #5ms;
        $display("FAIL time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(posedge SYS_CLK);
        #1;
        SYS_RST = 1'b0;
        #1;
        check("init_alive", M2_ALIVE, 0);
        check("init_data", REG_DATA, 0);

        // Five writes to $E000, D0 = 1,0,1,1,0.
        clear_obs();
        sw(1, 1, 0, 1); sw(1, 1, 0, 0); sw(1, 1, 0, 1); sw(1, 1, 0, 1); sw(1, 1, 0, 0);
        check("e000_we_count", n_we, 1);
        check("e000_sel", obs_sel, 2'b11);
        check("e000_data", obs_data, 5'b01101);
        check("e000_model", m_last_data, 5'b01101);
        check("alive_running", M2_ALIVE, 1);

        // Partial write, serial reset, then five ones to $A000.
        clear_obs();
        sw(0, 0, 0, 1); sw(0, 0, 0, 0); sw(0, 0, 0, 1); sw(0, 0, 1, 0);
        check("d7_rst_count", n_rst, 1);
        check("d7_no_we", n_we, 0);
        repeat (5) sw(0, 1, 0, 1);
        check("a000_we_count", n_we, 1);
        check("a000_sel", obs_sel, 2'b01);
        check("a000_data", obs_data, 5'b11111);

        // Back-to-back ROM writes, second with D7=1.
        clear_obs();
        cpu_cycle(0, 0, 0, 0, 0, 1, 4, 4);
        cpu_cycle(0, 0, 0, 0, 1, 0, 4, 4);
        cpu_cycle(0, 1, 0, 0, 0, 0, 3, 3);
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        check("rmw_filtered", n_rst, 0);
`else
        check("rmw_accepted", n_rst, 1);
`endif
        sw(0, 0, 1, 0);

        // ROM reads and $6000 RAM writes between serial writes to $8000.
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            bit b;
            b = (i == 0 || i == 1 || i == 4);
            cpu_cycle(0, 0, 0, 0, 0, b, 4, 4);
            cpu_cycle(0, 1, 1, 1, 0, 1, 3, 3);
            cpu_cycle(1, 0, 1, 1, 0, 1, 3, 3);
        end
        check("ilv_we_count", n_we, 1);
        check("ilv_sel", obs_sel, 2'b00);
        check("ilv_data", obs_data, 5'b10011);

        // M2 stops after two writes; recovery must use only new bits.
        clear_obs();
        sw(1, 0, 0, 1); sw(1, 0, 0, 1);
        repeat (T + 1) @(posedge SYS_CLK);
        #1;
        check("timeout_alive", M2_ALIVE, 0);
        sw(1, 0, 0, 0); sw(1, 0, 0, 1); sw(1, 0, 0, 0); sw(1, 0, 0, 0); sw(1, 0, 0, 0);
        check("tmo_we_count", n_we, 1);
        check("tmo_sel", obs_sel, 2'b10);
        check("tmo_data", obs_data, 5'b00010);

        // Reset mid-sequence discards the partial value.
        clear_obs();
        sw(1, 1, 0, 1); sw(1, 1, 0, 1); sw(1, 1, 0, 1);
        do_reset();
        check("mid_rst_data", REG_DATA, 0);
        check("mid_rst_sel", REG_SEL, 0);
        check("mid_rst_alive", M2_ALIVE, 0);
        sw(1, 1, 0, 0); sw(1, 1, 0, 0); sw(1, 1, 0, 1); sw(1, 1, 0, 1); sw(1, 1, 0, 1);
        check("post_rst_we_count", n_we, 1);
        check("post_rst_data", obs_data, 5'b11100);

        // Random traffic, including gaps around the watchdog limit.
        for (int i = 0; i < 400; i++) begin
            bit rs;
            bit rw;
            bit a14;
            bit a13;
            bit d7;
            bit d0;
            int hi;
            int lo;
            rs  = ($urandom_range(3) == 0);
            rw  = ($urandom_range(3) == 0);
            a14 = $urandom_range(1) == 1;
            a13 = $urandom_range(1) == 1;
            d7  = ($urandom_range(7) == 0);
            d0  = $urandom_range(1) == 1;
            hi  = $urandom_range(6, 2);
            lo  = $urandom_range(6, 3);
            if ($urandom_range(19) == 0) lo = $urandom_range(T + 2, T - 6);
            if ($urandom_range(149) == 0) do_reset();
            cpu_cycle(rs, rw, a14, a13, d7, d0, hi, lo);
        end

        repeat (10) @(posedge SYS_CLK);
        #1;
        check("queue_drained", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
